bp_stall_hist_ctrl: RTL and testbench
=====================================

// Module: bp_stall_hist_ctrl
// PURPOSE
//  Synthesizable controller for the per-core stall-reason histogram. It consumes the
//  encoded stall reason from the core profiler each cycle and maintains one saturating
//  counter per reason, plus instret and cycle counters. Host commands (start, stop, clear,
//  snapshot) sequence counting, and a valid/yumi read port returns snapshot values to the
//  zynq-parrot host shell.
// PARAMETERS
//  num_reasons_p  30  number of stall-reason bins; index 0 = unknown
//  cnt_width_p    32  width of every counter
//  lg_reasons_lp  $clog2(num_reasons_p+2)  localparam; read address width
// PORTS
//  clk_i           in   1              core clock
//  reset_i         in   1              async active-high reset
//  freeze_i        in   1              core frozen; gates all counting
//  instret_i       in   1              an instruction retired this cycle
//  stall_v_i       in   1              this cycle is a stall; qualified by ~instret_i
//  stall_reason_i  in   5              encoded stall reason (bp_stall_reason_e)
//  cmd_v_i         in   1              host command valid
//  cmd_op_i        in   2              00 start, 01 stop, 10 clear, 11 snapshot
//  cmd_ready_o     out  1              command accepted when cmd_v_i & cmd_ready_o
//  rd_v_i          in   1              read request valid
//  rd_addr_i       in   lg_reasons_lp  0..N-1 reason bin; N = instret; N+1 = cycles
//  rd_ready_o      out  1              read request accepted when rd_v_i & rd_ready_o
//  rd_data_v_o     out  1              read data valid; held until rd_yumi_i
//  rd_data_o       out  cnt_width_p    snapshot counter value
//  rd_yumi_i       in   1              host consumes rd_data_o
//  running_o       out  1              FSM is in e_run
//  overflow_o      out  1              sticky: some live counter saturated
// BEHAVIOUR
//  Reset (async): FSM e_idle; live and shadow counters 0; rd_data_v_o 0; rd_data_o 0;
//   overflow_o 0; running_o 0. cmd_ready_o and rd_ready_o are 1 once reset deasserts.
//  FSM e_idle <-> e_run. Start in e_idle moves to e_run on the next edge; stop in e_run
//   moves to e_idle. Start in e_run and stop in e_idle are accepted no-ops.
//   Clear and snapshot are accepted in either state and do not change the state.
//  Counting happens only on edges where state==e_run & ~freeze_i. The first counted
//   cycle is the one after the start command is accepted.
//   - cycle counter increments every counted cycle.
//   - instret_i=1: instret counter increments; stall inputs are ignored.
//   - else stall_v_i=1: hist[stall_reason_i] increments. A reason >= num_reasons_p
//     increments bin 0.
//   - Counters saturate at all-ones and do not wrap. Any saturating increment sets
//     overflow_o.
//  Clear: all live counters and overflow_o go to 0 on the accept edge. A clear overrides
//   any increment in the same cycle, so that cycle is not counted. Shadow bank unchanged.
//  Snapshot: all N+2 live counters are copied to the shadow bank atomically on the accept
//   edge. The copy takes pre-increment values; the live increment in that cycle still occurs.
//  cmd_ready_o = ~(rd_data_v_o & ~rd_yumi_i). A snapshot or any other command is never
//   accepted while unconsumed read data is pending.
//  Reads: rd_ready_o = ~rd_data_v_o | rd_yumi_i. On accept, rd_data_o <= shadow[rd_addr_i]
//   and rd_data_v_o <= 1 the next cycle (1-cycle latency). Data is held stable until
//   rd_yumi_i. If a yumi and a new accept fall in the same cycle, new data appears the next
//   cycle with no bubble. An out-of-range address returns 0 with valid.
//  cmd and read in the same cycle are independent. If a command is accepted in the same
//   cycle as a read, the read returns the shadow bank value from before that edge.
//  reset_i mid-read drops pending data (rd_data_v_o to 0). No partial state survives.
// TESTING
//  start; 10 cycles stall reason 2; stop; snapshot; read addr 2 -> 10; read N+1 -> 10.
//  run with instret_i=1 & stall_v_i=1 for 5 cycles -> instret=5, every hist bin 0.
//  clear and stall in same cycle while running -> that bin 0; shadow keeps older values.
//  cnt_width_p=4, 20 stalls reason 7 -> bin 7 = 15, overflow_o=1; clear -> overflow_o=0.
//  freeze_i high for 3 of 8 run cycles -> cycle counter = 5; reason 31 -> bin 0.
//  read issued, rd_yumi_i held low 4 cycles -> rd_data_o stable; cmd_ready_o=0; snapshot
//   waits until yumi.

Source files
------------

// File: rtl/bp_stall_hist_ctrl.sv
// Per-core stall-reason histogram: saturating live counters, a shadow bank
// copied on snapshot, and a valid/yumi read port onto the shadow bank.
module bp_stall_hist_ctrl #(
    parameter int unsigned num_reasons_p = 30,
    parameter int unsigned cnt_width_p   = 32,
    localparam int unsigned lg_reasons_lp = $clog2(num_reasons_p + 2)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     freeze_i,
    input  logic                     instret_i,
    input  logic                     stall_v_i,
    input  logic [4:0]               stall_reason_i,
    input  logic                     cmd_v_i,
    input  logic [1:0]               cmd_op_i,
    output logic                     cmd_ready_o,
    input  logic                     rd_v_i,
    input  logic [lg_reasons_lp-1:0] rd_addr_i,
    output logic                     rd_ready_o,
    output logic                     rd_data_v_o,
    output logic [cnt_width_p-1:0]   rd_data_o,
    input  logic                     rd_yumi_i,
    output logic                     running_o,
    output logic                     overflow_o
);

    localparam int unsigned num_cnt_lp     = num_reasons_p + 2;
    localparam int unsigned instret_idx_lp = num_reasons_p;
    localparam int unsigned cycle_idx_lp   = num_reasons_p + 1;

    typedef enum logic {e_idle, e_run} state_e;
    typedef enum logic [1:0] {
        e_op_start    = 2'b00,
        e_op_stop     = 2'b01,
        e_op_clear    = 2'b10,
        e_op_snapshot = 2'b11
    } cmd_op_e;

    state_e                   state_q;
    logic [cnt_width_p-1:0]   live_q   [num_cnt_lp];
    logic [cnt_width_p-1:0]   live_d   [num_cnt_lp];
    logic [cnt_width_p-1:0]   shadow_q [num_cnt_lp];
    logic                     overflow_q, overflow_d;
    logic                     rd_data_v_q;
    logic [cnt_width_p-1:0]   rd_data_q, rd_data_d;

    logic                     cmd_acc, rd_acc, clear_c, snap_c, count_en_c;
    cmd_op_e                  op_c;
    logic [lg_reasons_lp-1:0] bin_c;
    logic [num_cnt_lp-1:0]    inc_c, sat_c;

    assign cmd_ready_o = ~(rd_data_v_q & ~rd_yumi_i);
    assign rd_ready_o  = ~rd_data_v_q | rd_yumi_i;
    assign cmd_acc     = cmd_v_i & cmd_ready_o;
    assign rd_acc      = rd_v_i & rd_ready_o;
    assign op_c        = cmd_op_e'(cmd_op_i);
    assign clear_c     = cmd_acc & (op_c == e_op_clear);
    assign snap_c      = cmd_acc & (op_c == e_op_snapshot);
    assign count_en_c  = (state_q == e_run) & ~freeze_i;

    // Unknown/out-of-range reasons fold into bin 0.
    assign bin_c = (32'(stall_reason_i) >= num_reasons_p) ? '0
                                                          : lg_reasons_lp'(stall_reason_i);

    always_comb begin
        inc_c = '0;
        if (count_en_c) begin
            inc_c[cycle_idx_lp] = 1'b1;
            if (instret_i) begin
                inc_c[instret_idx_lp] = 1'b1;
            end else if (stall_v_i) begin
                inc_c[bin_c] = 1'b1;
            end
        end
    end

    // Saturating next values; clear wins over any same-cycle increment.
    always_comb begin
        sat_c = '0;
        for (int i = 0; i < int'(num_cnt_lp); i++) begin
            live_d[i] = live_q[i];
            sat_c[i]  = inc_c[i] & (&live_q[i]);
            if (clear_c) begin
                live_d[i] = '0;
            end else if (inc_c[i] && !sat_c[i]) begin
                live_d[i] = live_q[i] + cnt_width_p'(1);
            end
        end
        overflow_d = clear_c ? 1'b0 : (overflow_q | (|sat_c));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
        end else if (cmd_acc) begin
            case (state_q)
                e_idle:  if (op_c == e_op_start) state_q <= e_run;
                e_run:   if (op_c == e_op_stop)  state_q <= e_idle;
                default: state_q <= e_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(num_cnt_lp); i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(num_cnt_lp); i++) begin
                live_q[i] <= live_d[i];
                if (snap_c) shadow_q[i] <= live_q[i];
            end
            overflow_q <= overflow_d;
        end
    end

    assign rd_data_d = (32'(rd_addr_i) < num_cnt_lp) ? shadow_q[rd_addr_i] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_v_q <= 1'b0;
            rd_data_q   <= '0;
        end else if (rd_acc) begin
            rd_data_v_q <= 1'b1;
            rd_data_q   <= rd_data_d;
        end else if (rd_yumi_i) begin
            rd_data_v_q <= 1'b0;
        end
    end

    assign rd_data_v_o = rd_data_v_q;
    assign rd_data_o   = rd_data_q;
    assign running_o   = (state_q == e_run);
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bp_stall_hist_ctrl.sv
// Directed bench: a 32-bit and a 4-bit instance share stimulus; read results
// are checked against per-instance expected-value queues.
module tb_bp_stall_hist_ctrl;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SNAP  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, instret, stall_v, cmd_v, rd_v, rd_yumi;
    logic [4:0]  stall_reason, rd_addr;
    logic [1:0]  cmd_op;

    logic        b_cmd_ready, b_rd_ready, b_rd_data_v, b_running, b_overflow;
    logic [31:0] b_rd_data;
    logic        s_cmd_ready, s_rd_ready, s_rd_data_v, s_running, s_overflow;
    logic [3:0]  s_rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q_b[$];
    logic [31:0] q_s[$];

    always #5 clk = ~clk;

    bp_stall_hist_ctrl #(.num_reasons_p(30), .cnt_width_p(32)) u_big (
        .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .instret_i(instret),
        .stall_v_i(stall_v), .stall_reason_i(stall_reason),
        .cmd_v_i(cmd_v), .cmd_op_i(cmd_op), .cmd_ready_o(b_cmd_ready),
        .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(b_rd_ready),
        .rd_data_v_o(b_rd_data_v), .rd_data_o(b_rd_data), .rd_yumi_i(rd_yumi),
        .running_o(b_running), .overflow_o(b_overflow)
    );

    bp_stall_hist_ctrl #(.num_reasons_p(30), .cnt_width_p(4)) u_small (
        .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .instret_i(instret),
        .stall_v_i(stall_v), .stall_reason_i(stall_reason),
        .cmd_v_i(cmd_v), .cmd_op_i(cmd_op), .cmd_ready_o(s_cmd_ready),
        .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(s_rd_ready),
        .rd_data_v_o(s_rd_data_v), .rd_data_o(s_rd_data), .rd_yumi_i(rd_yumi),
        .running_o(s_running), .overflow_o(s_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op);
        cmd_v  = 1'b1;
        cmd_op = op;
        tick();
        cmd_v  = 1'b0;
    endtask

    // Compare the head of the queues with the presented read data, then pop.
    task automatic rd_compare(input string tag);
        check({tag, "_v"},   32'(b_rd_data_v), 32'd1);
        check({tag, "_v_s"}, 32'(s_rd_data_v), 32'd1);
        if (q_b.size() == 0 || q_s.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed data with empty queue, expected a queued entry", tag);
        end else begin
            check(tag,           b_rd_data,      q_b.pop_front());
            check({tag, "_s"},   32'(s_rd_data), q_s.pop_front());
        end
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] eb,
                      input logic [31:0] es, input string tag);
        rd_v    = 1'b1;
        rd_addr = addr;
        q_b.push_back(eb);
        q_s.push_back(es);
        tick();
        rd_v = 1'b0;
        rd_compare(tag);
        rd_yumi = 1'b1;
        tick();
        rd_yumi = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; instret = 1'b0; stall_v = 1'b0; stall_reason = '0;
        cmd_v = 1'b0; cmd_op = '0; rd_v = 1'b0; rd_addr = '0; rd_yumi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_running",  32'(b_running),   32'd0);
        check("rst_overflow", 32'(b_overflow),  32'd0);
        check("rst_rd_v",     32'(b_rd_data_v), 32'd0);
        check("rst_rd_data",  b_rd_data,        32'd0);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(b_cmd_ready), 32'd1);
        check("rst_rd_ready",  32'(b_rd_ready),  32'd1);
        cmd(OP_SNAP);
        rd(5'd7, 32'd0, 32'd0, "rst_bin7");

        // 10 counted stall cycles of reason 2; stop lands on the 10th
        cmd(OP_START);
        check("start_running", 32'(b_running), 32'd1);
        stall_v = 1'b1; stall_reason = 5'd2;
        repeat (9) tick();
        cmd(OP_STOP);
        stall_v = 1'b0;
        check("stop_running", 32'(b_running), 32'd0);
        cmd(OP_SNAP);
        rd(5'd2,  32'd10, 32'd10, "s2_bin2");
        rd(5'd31, 32'd10, 32'd10, "s2_cycles");
        rd(5'd30, 32'd0,  32'd0,  "s2_instret");
        rd(5'd5,  32'd0,  32'd0,  "s2_bin5");

        // instret has priority over stall
        cmd(OP_CLEAR);
        cmd(OP_START);
        instret = 1'b1; stall_v = 1'b1; stall_reason = 5'd3;
        repeat (4) tick();
        cmd(OP_STOP);
        instret = 1'b0; stall_v = 1'b0;
        cmd(OP_SNAP);
        rd(5'd30, 32'd5, 32'd5, "s3_instret");
        rd(5'd3,  32'd0, 32'd0, "s3_bin3");
        rd(5'd2,  32'd0, 32'd0, "s3_bin2_cleared");
        rd(5'd31, 32'd5, 32'd5, "s3_cycles");

        // clear while stalling in run: that cycle is not counted; shadow kept
        cmd(OP_START);
        stall_v = 1'b1; stall_reason = 5'd4;
        repeat (2) tick();
        cmd(OP_CLEAR);
        stall_v = 1'b0;
        check("clr_running", 32'(b_running), 32'd1);
        cmd(OP_STOP);
        rd(5'd30, 32'd5, 32'd5, "s4_shadow_kept");
        cmd(OP_SNAP);
        rd(5'd4,  32'd0, 32'd0, "s4_bin4");
        rd(5'd31, 32'd1, 32'd1, "s4_cycles");

        // freeze for 3 of 8 run cycles; reason 31 folds into bin 0
        cmd(OP_CLEAR);
        cmd(OP_START);
        stall_v = 1'b1; stall_reason = 5'd31;
        for (int i = 0; i < 7; i++) begin
            freeze = (i == 1 || i == 3 || i == 4);
            tick();
        end
        freeze = 1'b0;
        cmd(OP_STOP);
        stall_v = 1'b0;
        cmd(OP_SNAP);
        rd(5'd0,  32'd5, 32'd5, "s5_bin0");
        rd(5'd31, 32'd5, 32'd5, "s5_cycles");

        // 20 stalls of reason 7: 4-bit instance saturates at 15
        cmd(OP_CLEAR);
        cmd(OP_START);
        stall_v = 1'b1; stall_reason = 5'd7;
        repeat (19) tick();
        cmd(OP_STOP);
        stall_v = 1'b0;
        check("s6_ovf_big",   32'(b_overflow), 32'd0);
        check("s6_ovf_small", 32'(s_overflow), 32'd1);
        cmd(OP_SNAP);
        rd(5'd7,  32'd20, 32'd15, "s6_bin7");
        rd(5'd31, 32'd20, 32'd15, "s6_cycles");
        cmd(OP_CLEAR);
        check("s6_ovf_cleared", 32'(s_overflow), 32'd0);

        // live bin7 = 3 while shadow bin7 = 20 (15 small)
        cmd(OP_START);
        stall_v = 1'b1; stall_reason = 5'd7;
        repeat (2) tick();
        cmd(OP_STOP);
        stall_v = 1'b0;

        // data held while yumi low; snapshot stalls until yumi
        rd_v = 1'b1; rd_addr = 5'd7;
        q_b.push_back(32'd20); q_s.push_back(32'd15);
        tick();
        rd_v = 1'b0;
        cmd_v = 1'b1; cmd_op = OP_SNAP;
        for (int i = 0; i < 4; i++) begin
            check("hold_v",         32'(b_rd_data_v), 32'd1);
            check("hold_data",      b_rd_data,        32'd20);
            check("hold_cmd_ready", 32'(b_cmd_ready), 32'd0);
            check("hold_rd_ready",  32'(b_rd_ready),  32'd0);
            tick();
        end
        rd_yumi = 1'b1;
        #1;
        check("yumi_cmd_ready", 32'(b_cmd_ready), 32'd1);
        rd_compare("hold_final");
        tick();
        rd_yumi = 1'b0; cmd_v = 1'b0;
        check("yumi_v_drop", 32'(b_rd_data_v), 32'd0);
        rd(5'd7, 32'd3, 32'd3, "s7_bin7_after_snap");

        // yumi and new accept in one cycle: no bubble
        rd_v = 1'b1; rd_addr = 5'd7;
        q_b.push_back(32'd3); q_s.push_back(32'd3);
        tick();
        rd_compare("b2b_first");
        rd_yumi = 1'b1; rd_addr = 5'd30;
        q_b.push_back(32'd0); q_s.push_back(32'd0);
        #1;
        check("b2b_rd_ready", 32'(b_rd_ready), 32'd1);
        tick();
        rd_v = 1'b0; rd_yumi = 1'b0;
        rd_compare("b2b_second");
        rd_yumi = 1'b1;
        tick();
        rd_yumi = 1'b0;

        // reset with read data pending
        cmd(OP_START);
        rd_v = 1'b1; rd_addr = 5'd7;
        tick();
        rd_v = 1'b0;
        check("mid_v_before", 32'(b_rd_data_v), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_v",       32'(b_rd_data_v), 32'd0);
        check("mid_rst_data",    b_rd_data,        32'd0);
        check("mid_rst_running", 32'(b_running),   32'd0);
        tick();
        rst = 1'b0;
        tick();
        cmd(OP_SNAP);
        rd(5'd31, 32'd0, 32'd0, "mid_rst_cycles");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
